// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the register file write port (we/A3/WD3) between the core writeback
// path (requester 0) and the debug/loader path (requester 1). Grants alternate
// round-robin, and every grant is registered onto the write port one cycle
// later. Writes to $zero still complete their handshake, but they leave rf_we
// low and bump a saturating counter.
//
// Optional feature macro: RF_CLEAR_EN. When it is defined, a post-reset sweep
// writes 0 to registers 1..NUM_REGS-1 before any requester is served.
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req0_valid/addr/data  writeback request          -> req0_ready
//   req1_valid/addr/data  debug/loader request       -> req1_ready
//   rf_we, rf_A3, rf_WD3  registered register file write port
//   init_done             high once requesters may be served
//   last_grant            id of the most recently accepted requester
//   zero_wr_cnt           saturating count of accepted writes to address 0
module rf_write_arbiter #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_A3,
  output logic [DATA_W-1:0] rf_WD3,
  output logic              init_done,
  output logic              last_grant,
  output logic [CNT_W-1:0]  zero_wr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic              lg_q, lg_d;
  logic              ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              run_c;
  logic              grant_c;
  logic              win_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic [DATA_W-1:0] win_data_c;

`ifdef RF_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              init_q, init_d;

  assign run_c     = (state_q == ST_RUN);
  assign init_done = init_q;
`else
  assign run_c     = 1'b1;
  assign init_done = 1'b1;
`endif

  // Round-robin readies: a lone requester always wins; on a tie the pointer decides.
  assign req0_ready = run_c & req0_valid & (~req1_valid | ~ptr_q);
  assign req1_ready = run_c & req1_valid & (~req0_valid |  ptr_q);

  assign grant_c    = req0_ready | req1_ready;
  assign win_c      = req1_ready;
  assign win_addr_c = win_c ? req1_addr : req0_addr;
  assign win_data_c = win_c ? req1_data : req0_data;

  // Next-state computation for the write port, arbitration and sweep.
  always_comb begin
    we_d  = 1'b0;
    a3_d  = a3_q;
    wd_d  = wd_q;
    lg_d  = lg_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
`ifdef RF_CLEAR_EN
    state_d = state_q;
    idx_d   = idx_q;
    init_d  = init_q;
    if (state_q == ST_CLEAR) begin
      we_d  = 1'b1;
      a3_d  = idx_q;
      wd_d  = '0;
      idx_d = idx_q + ADDR_W'(1);
      if (idx_q == LAST_IDX) begin
        state_d = ST_RUN;
        init_d  = 1'b1;
      end
    end
`endif
    if (grant_c) begin
      a3_d  = win_addr_c;
      wd_d  = win_data_c;
      we_d  = (win_addr_c != '0);
      lg_d  = win_c;
      ptr_d = ~win_c;
      // $zero writes are absorbed: the handshake completes but only the counter moves.
      if ((win_addr_c == '0) && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      a3_q    <= '0;
      wd_q    <= '0;
      lg_q    <= 1'b0;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef RF_CLEAR_EN
      state_q <= ST_CLEAR;
      idx_q   <= ADDR_W'(1);
      init_q  <= 1'b0;
`endif
    end else begin
      we_q    <= we_d;
      a3_q    <= a3_d;
      wd_q    <= wd_d;
      lg_q    <= lg_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
`ifdef RF_CLEAR_EN
      state_q <= state_d;
      idx_q   <= idx_d;
      init_q  <= init_d;
`endif
    end
  end

  assign rf_we       = we_q;
  assign rf_A3       = a3_q;
  assign rf_WD3      = wd_q;
  assign last_grant  = lg_q;
  assign zero_wr_cnt = cnt_q;

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the register file's single write port (we/A3/WD3) between two requesters: requester 0 is the core writeback path, requester 1 is the debug/loader path. Both use a valid/ready handshake and are served round-robin. Every grant is registered onto the write port. Writes to $zero are absorbed and counted. An optional post-reset sweep clears registers 1..NUM_REGS-1 before any requester is served.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- NUM_REGS, 32, registers in the file (index 0 is $zero)
- CNT_W, 8, width of the $zero-write counter
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  writeback request
- req0_addr  in  ADDR_W  writeback destination
- req0_data  in  DATA_W  writeback data
- req0_ready  out  1  writeback accepted this cycle
- req1_valid  in  1  debug/loader request
- req1_addr  in  ADDR_W  debug destination
- req1_data  in  DATA_W  debug data
- req1_ready  out  1  debug accepted this cycle
- rf_we  out  1  to register file we
- rf_A3  out  ADDR_W  to register file A3
- rf_WD3  out  DATA_W  to register file WD3
- init_done  out  1  high once requesters may be served
- last_grant  out  1  id of the most recently accepted requester
- zero_wr_cnt  out  CNT_W  saturating count of accepted writes to address 0

## Operation
- States:
  - CLEAR: only exists with RF_CLEAR_EN.
  - RUN.
- Reset values:
  - rf_we=0, rf_A3=0, rf_WD3=0, last_grant=0, zero_wr_cnt=0.
  - Internal priority pointer = 0.
  - Sweep index = 1.
- Reset state and init_done:
  - With RF_CLEAR_EN: state=CLEAR, init_done=0.
  - Without RF_CLEAR_EN: state=RUN, init_done=1.
- CLEAR:
  - Each cycle, register rf_we=1, rf_A3=index, rf_WD3=0, then increment index.
  - After the edge that issues index NUM_REGS-1, go to RUN and set init_done=1.
  - req0_ready and req1_ready are held at 0 throughout CLEAR.
- RUN, readies (combinational from valids, pointer and state):
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester named by the pointer gets ready=1, the other gets 0.
  - Neither valid: both readies are 0.
- Acceptance: a request is accepted when valid&&ready at a rising edge. On that edge:
  - rf_A3 and rf_WD3 load the winner's addr and data.
  - rf_we loads (addr!=0).
  - last_grant loads the winner id.
  - The pointer loads the loser id, i.e. it flips only when a grant occurs.
- No acceptance in RUN: rf_we loads 0; rf_A3 and rf_WD3 hold their values.
- $zero writes:
  - An accepted write to address 0 completes its handshake but produces rf_we=0.
  - zero_wr_cnt increments and saturates at all-ones.
- Requester obligations: hold valid, addr and data stable until ready. The block does not check this.

## Timing
- Accept to write-port drive: 1 cycle. rf_we/rf_A3/rf_WD3 change at the accepting edge. The register file commits at the next edge, so the write is visible on its read ports 2 edges after acceptance.
- Throughput: one write per cycle. With both requesters continuously valid, grants alternate 0,1,0,1… starting with the pointer value.
- Simultaneous request with pointer=0: req0 wins; req1 wins on the next cycle if it is still valid.
- CLEAR length: exactly NUM_REGS-1 cycles of rf_we=1. init_done rises on the same edge that issues the last sweep write. The first request can be accepted at the following edge.
- A request raised during CLEAR waits, with ready=0, until the RUN cycle; no request is lost.
- Reset asserted mid-operation:
  - All outputs go to their reset values immediately (asynchronously). rf_we=0 cuts any in-flight write.
  - With RF_CLEAR_EN, the sweep restarts from index 1 after release.

## Configuration
- RF_CLEAR_EN defined:
  - CLEAR state and sweep counter are present.
  - Reset enters CLEAR with init_done=0.
  - Registers 1..NUM_REGS-1 read 0 once init_done is high.
- RF_CLEAR_EN undefined:
  - No sweep logic is present.
  - Reset enters RUN with init_done=1.
  - Register contents after reset are whatever the register file holds.

## Test plan
- Reset with RF_CLEAR_EN, no requests:
  - Required: 31 consecutive rf_we pulses, rf_A3=1..31, rf_WD3=0.
  - init_done=1 after the 31st; all register file reads return 0.
- req0 valid during CLEAR with addr=8, data=12345678:
  - Required: req0_ready=0 until RUN; accepted on the first RUN edge.
  - rf_we=1 with rf_A3=8 on the next cycle; $t0 reads 12345678 one edge later.
- Both valid every cycle after init (req0: addr 9, data ABCDEF01; req1: addr 16, data 55AA55AA):
  - Required: grants alternate 0,1,0,1; last_grant toggles; no cycle has both readies high.
- req1 valid with addr=0, data=DEADBEEF:
  - Required: req1_ready=1 and rf_we=0 the next cycle; zero_wr_cnt increments by 1; $zero still reads 0.
- 300 accepted $zero writes with CNT_W=8: required zero_wr_cnt=255 (saturated).
- Assert rst_n mid-sweep at index 10:
  - Required: rf_we=0 immediately.
  - After release, the sweep restarts with rf_A3=1.
